// File: rtl/coco_pkg.sv
// Shared phase constants and types for the CoCo SAM-style RAM slot controller.
package coco_pkg;

  typedef logic [3:0] phase_t;

  localparam phase_t PH_VID_ADDR = 4'd1;
  localparam phase_t PH_VID_LAT  = 4'd3;
  localparam phase_t PH_CPU_ADDR = 4'd9;
  localparam phase_t PH_CPU_LAT  = 4'd11;

  localparam phase_t Q_LO = 4'd4;
  localparam phase_t Q_HI = 4'd11;
  localparam phase_t E_LO = 4'd8;
  localparam phase_t E_HI = 4'd15;

  function automatic logic in_window(phase_t ph, phase_t lo, phase_t hi);
    return (ph >= lo) && (ph <= hi);
  endfunction

endpackage

// File: rtl/coco_rr_arbiter.sv
// Combinational round-robin arbiter: scans requests starting one past the last winner.
module coco_rr_arbiter #(
  parameter int unsigned NCH  = 2,
  parameter int unsigned CH_W = 1
) (
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] ptr,
  output logic [NCH-1:0]  gnt,
  output logic [CH_W-1:0] idx,
  output logic            found
);

  logic [CH_W-1:0] ch;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    ch    = '0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      ch = CH_W'((32'(ptr) + i) % NCH);
      if (!found && req[ch]) begin
        found   = 1'b1;
        gnt[ch] = 1'b1;
        idx     = ch;
      end
    end
  end

endmodule

// File: rtl/coco_ram_slot_ctrl.sv
// RAM time-slot controller: pixel-rate divider, 16-phase E/Q cycle, and one video/DMA fetch
// plus one CPU access per CPU cycle on a single-port synchronous RAM.
module coco_ram_slot_ctrl
  import coco_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NCH     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  clk_ena,
  output logic                  e,
  output logic                  q,
  output logic [3:0]            phase,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic                  cpu_rw,
  input  logic                  cpu_ram_sel,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic [DATA_W-1:0]     cpu_rdata,
  input  logic [NCH-1:0]        vid_req,
  input  logic [NCH*ADDR_W-1:0] vid_addr,
  output logic [NCH-1:0]        vid_gnt,
  output logic [NCH-1:0]        vid_valid,
  output logic [DATA_W-1:0]     vid_data,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_we,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata
);

  localparam int unsigned CH_W     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0]      div_q;
  logic            run_q;
  phase_t          phase_q, phase_d;
  logic [CH_W-1:0] ptr_q;
  logic [NCH-1:0]  pend_gnt_q;
  logic            cpu_rd_pend_q;

  logic [NCH-1:0]    arb_gnt;
  logic [CH_W-1:0]   arb_idx;
  logic              arb_found;
  logic [ADDR_W-1:0] ch_addr [NCH];
  logic [ADDR_W-1:0] win_addr;
  logic              vid_slot, vid_lat_slot, cpu_slot, cpu_lat_slot;

  for (genvar g = 0; g < NCH; g++) begin : g_ch_addr
    assign ch_addr[g] = vid_addr[g*ADDR_W +: ADDR_W];
  end

  coco_rr_arbiter #(
    .NCH  (NCH),
    .CH_W (CH_W)
  ) u_arb (
    .req   (vid_req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .found (arb_found)
  );

  // run_q keeps clk_ena low while in reset even when CLK_DIV=1 makes the wrap compare constant.
  assign clk_ena      = run_q & (div_q == DIV_LAST);
  assign phase        = phase_q;
  assign phase_d      = clk_ena ? phase_q + 4'd1 : phase_q;
  assign win_addr     = ch_addr[arb_idx];
  assign vid_slot     = clk_ena && (phase_q == PH_VID_ADDR);
  assign vid_lat_slot = clk_ena && (phase_q == PH_VID_LAT);
  assign cpu_slot     = clk_ena && (phase_q == PH_CPU_ADDR);
  assign cpu_lat_slot = clk_ena && (phase_q == PH_CPU_LAT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q         <= '0;
      run_q         <= 1'b0;
      phase_q       <= '0;
      e             <= 1'b0;
      q             <= 1'b0;
      ptr_q         <= CH_W'(NCH - 1);
      pend_gnt_q    <= '0;
      cpu_rd_pend_q <= 1'b0;
      vid_gnt       <= '0;
      vid_valid     <= '0;
      vid_data      <= '0;
      cpu_rdata     <= '0;
      ram_addr      <= '0;
      ram_we        <= 1'b0;
      ram_wdata     <= '0;
    end else begin
      run_q     <= 1'b1;
      div_q     <= (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
      phase_q   <= phase_d;
      // Decode from the next phase so e/q line up with the phase they belong to.
      q         <= in_window(phase_d, Q_LO, Q_HI);
      e         <= in_window(phase_d, E_LO, E_HI);
      vid_gnt   <= '0;
      vid_valid <= '0;
      ram_we    <= 1'b0;

      if (vid_slot) begin
        pend_gnt_q <= arb_gnt;
        if (arb_found) begin
          vid_gnt  <= arb_gnt;
          ptr_q    <= arb_idx;
          ram_addr <= win_addr;
        end
      end

      if (vid_lat_slot) begin
        if (|pend_gnt_q) begin
          vid_data  <= ram_rdata;
          vid_valid <= pend_gnt_q;
        end
        pend_gnt_q <= '0;
      end

      if (cpu_slot) begin
        cpu_rd_pend_q <= cpu_ram_sel & cpu_rw;
        if (cpu_ram_sel) begin
          ram_addr <= cpu_addr;
          if (!cpu_rw) begin
            ram_wdata <= cpu_wdata;
            ram_we    <= 1'b1;
          end
        end
      end

      if (cpu_lat_slot) begin
        if (cpu_rd_pend_q) cpu_rdata <= ram_rdata;
        cpu_rd_pend_q <= 1'b0;
      end
    end
  end

endmodule
